// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_predict_resolve
// Description : Direct-mapped 2-bit bimodal predictor with EX-stage branch
//               resolution, misprediction redirect and performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int IDX_W = 6
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] if_pc_i,
    output logic        pred_taken_o,

    input  logic        ex_valid_i,
    input  logic        ex_is_br_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,

    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        br_unsign_o,

    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,

    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int         c_DEPTH     = 2 ** IDX_W;
    localparam logic [1:0] c_CTR_RESET = 2'b01;
    localparam logic [1:0] c_CTR_MAX   = 2'b11;
    localparam logic [1:0] c_CTR_MIN   = 2'b00;

    logic [1:0]       r_table [c_DEPTH];
    logic [31:0]      r_br_cnt;
    logic [31:0]      r_mispred_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_legal;
    logic             w_taken;
    logic             w_res;
    logic             w_mispred;
    logic [1:0]       w_cur_ctr;
    logic [1:0]       w_next_ctr;
    logic [31:0]      w_fallthru_pc;
    logic             w_unused;

    assign w_if_idx = if_pc_i[IDX_W+1:2];
    assign w_ex_idx = ex_pc_i[IDX_W+1:2];

    // Table read is a plain mux: a same-cycle EX update is not bypassed.
    assign pred_taken_o = r_table[w_if_idx][1];

    // funct3[1] separates the unsigned compares (BLTU/BGEU) from the signed.
    assign br_unsign_o = ex_funct3_i[1];

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (ex_funct3_i)
            3'b000:          w_taken = br_equal_i;
            3'b001:          w_taken = ~br_equal_i;
            3'b100, 3'b110:  w_taken = br_less_i;
            3'b101, 3'b111:  w_taken = ~br_less_i;
            default:         w_legal = 1'b0;
        endcase
    end

    assign w_res     = ex_valid_i & ex_is_br_i & w_legal;
    assign w_mispred = w_res & (w_taken != ex_pred_taken_i);

    assign redirect_o = w_mispred & ~rst_i;
    assign flush_o    = redirect_o;

    assign w_fallthru_pc = ex_pc_i + 32'd4;
    assign redirect_pc_o = w_taken ? ex_target_i : w_fallthru_pc;

    // Training uses the stored counter, not the prediction carried down the pipe.
    assign w_cur_ctr = r_table[w_ex_idx];

    always_comb begin
        w_next_ctr = w_cur_ctr;
        if (w_taken) begin
            if (w_cur_ctr != c_CTR_MAX) begin
                w_next_ctr = w_cur_ctr + 2'd1;
            end
        end else begin
            if (w_cur_ctr != c_CTR_MIN) begin
                w_next_ctr = w_cur_ctr - 2'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_table[i] <= c_CTR_RESET;
            end
        end else if (w_res) begin
            r_table[w_ex_idx] <= w_next_ctr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
        end else if (w_res) begin
            r_br_cnt <= r_br_cnt + 32'd1;
            if (w_mispred) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

    assign w_unused = ^{if_pc_i[31:IDX_W+2], if_pc_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predict_resolve
// Description : Directed bench with a bimodal reference model and literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_is_br;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic        br_less;
    logic        br_equal;
    logic        br_unsign;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int          m_tbl [64];
    logic [31:0] m_br;
    logic [31:0] m_mis;

    always #5 clk = ~clk;

    branch_predict_resolve #(.IDX_W(6)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .if_pc_i         (if_pc),
        .pred_taken_o    (pred_taken),
        .ex_valid_i      (ex_valid),
        .ex_is_br_i      (ex_is_br),
        .ex_funct3_i     (ex_funct3),
        .ex_pc_i         (ex_pc),
        .ex_target_i     (ex_target),
        .ex_pred_taken_i (ex_pred_taken),
        .br_less_i       (br_less),
        .br_equal_i      (br_equal),
        .br_unsign_o     (br_unsign),
        .redirect_o      (redirect),
        .redirect_pc_o   (redirect_pc),
        .flush_o         (flush),
        .br_cnt_o        (br_cnt),
        .mispred_cnt_o   (mispred_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference semantics: which funct3 codes are branches, and what each one tests.
    function automatic bit m_legal(input logic [2:0] f3);
        return !(f3 == 3'd2 || f3 == 3'd3);
    endfunction

    function automatic bit m_taken(input logic [2:0] f3, input logic less, input logic eq);
        case (f3)
            3'd0:    return eq;
            3'd1:    return !eq;
            3'd4:    return less;
            3'd6:    return less;
            3'd5:    return !less;
            3'd7:    return !less;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_res();
        return ex_valid && ex_is_br && m_legal(ex_funct3);
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) m_tbl[i] = 1;
        m_br  = 0;
        m_mis = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) m_tbl[i] = 1;
            m_br  = 0;
            m_mis = 0;
        end else if (m_res()) begin
            bit t;
            int k;
            t = m_taken(ex_funct3, br_less, br_equal);
            k = m_idx(ex_pc);
            m_br = m_br + 1;
            if (t != ex_pred_taken) m_mis = m_mis + 1;
            if (t) m_tbl[k] = (m_tbl[k] == 3) ? 3 : m_tbl[k] + 1;
            else   m_tbl[k] = (m_tbl[k] == 0) ? 0 : m_tbl[k] - 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit t;
            bit exp_redir;
            t = m_taken(ex_funct3, br_less, br_equal);
            exp_redir = !rst && m_res() && (t != ex_pred_taken);
            check("m_pred_taken", {31'd0, pred_taken}, {31'd0, m_tbl[m_idx(if_pc)] >= 2});
            check("m_br_unsign",  {31'd0, br_unsign},  {31'd0, ex_funct3 == 3'd6 || ex_funct3 == 3'd7 ||
                                                                ex_funct3 == 3'd2 || ex_funct3 == 3'd3});
            check("m_redirect",   {31'd0, redirect},   {31'd0, exp_redir});
            check("m_flush",      {31'd0, flush},      {31'd0, exp_redir});
            check("m_br_cnt",     br_cnt,              m_br);
            check("m_mispred_cnt", mispred_cnt,        m_mis);
            if (m_res())
                check("m_redirect_pc", redirect_pc, t ? ex_target : ex_pc + 32'd4);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pred, input logic less, input logic eq);
        ex_valid      = 1'b1;
        ex_is_br      = 1'b1;
        ex_funct3     = f3;
        ex_pc         = pc;
        ex_target     = tgt;
        ex_pred_taken = pred;
        br_less       = less;
        br_equal      = eq;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_is_br = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        ex_valid = 1'b0; ex_is_br = 1'b0; ex_funct3 = 3'd0;
        ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0;
        br_less = 1'b0; br_equal = 1'b0;

        // 1: reset state
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst_pred", {31'd0, pred_taken}, 32'd0);
        check("rst_br_cnt", br_cnt, 32'd0);
        check("rst_mis_cnt", mispred_cnt, 32'd0);

        // 2: BEQ taken, predicted not-taken
        step();
        drive_br(3'd0, 32'h100, 32'h140, 1'b0, 1'b0, 1'b1);
        #1;
        check("beq_redirect", {31'd0, redirect}, 32'd1);
        check("beq_flush", {31'd0, flush}, 32'd1);
        check("beq_rpc", redirect_pc, 32'h140);
        step();
        idle_ex();
        #1;
        check("beq_pred_after", {31'd0, pred_taken}, 32'd1);
        check("beq_br_cnt", br_cnt, 32'd1);
        check("beq_mis_cnt", mispred_cnt, 32'd1);

        // 3: BLTU not-taken, then saturate down (0x200 shares index 0 with 0x100)
        step();
        if_pc = 32'h200;
        drive_br(3'd6, 32'h200, 32'h280, 1'b1, 1'b0, 1'b0);
        #1;
        check("bltu_unsign", {31'd0, br_unsign}, 32'd1);
        check("bltu_rpc", redirect_pc, 32'h204);
        check("bltu_redirect", {31'd0, redirect}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            drive_br(3'd6, 32'h200, 32'h280, 1'b0, 1'b0, 1'b0);
        end
        step();
        // Entry at 00: one taken only reaches 01, still predicting not-taken
        drive_br(3'd4, 32'h200, 32'h280, 1'b0, 1'b1, 1'b0);
        step();
        idle_ex();
        #1;
        check("sat_pred", {31'd0, pred_taken}, 32'd0);
        check("sat_br_cnt", br_cnt, 32'd8);
        check("sat_mis_cnt", mispred_cnt, 32'd3);

        // 4: illegal funct3
        step();
        drive_br(3'd2, 32'h100, 32'h180, 1'b0, 1'b1, 1'b1);
        #1;
        check("ill_redirect", {31'd0, redirect}, 32'd0);
        step();
        idle_ex();
        #1;
        check("ill_br_cnt", br_cnt, 32'd8);
        check("ill_mis_cnt", mispred_cnt, 32'd3);
        check("ill_pred", {31'd0, pred_taken}, 32'd0);

        // 5: read/write collision, no bypass
        step();
        if_pc = 32'h300;
        drive_br(3'd0, 32'h300, 32'h340, 1'b0, 1'b0, 1'b1);
        #1;
        check("coll_pred_now", {31'd0, pred_taken}, 32'd0);
        step();
        idle_ex();
        #1;
        check("coll_pred_next", {31'd0, pred_taken}, 32'd1);

        // 6: reset beats a mispredicted resolve; PC wrap on fall-through
        step();
        rst = 1'b1;
        drive_br(3'd0, 32'h300, 32'h340, 1'b1, 1'b0, 1'b0);
        #1;
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        step();
        rst = 1'b0;
        idle_ex();
        #1;
        check("rst2_br_cnt", br_cnt, 32'd0);
        check("rst2_mis_cnt", mispred_cnt, 32'd0);
        check("rst2_pred", {31'd0, pred_taken}, 32'd0);
        step();
        drive_br(3'd1, 32'hFFFF_FFFC, 32'h0000_1000, 1'b1, 1'b0, 1'b1);
        #1;
        check("wrap_rpc", redirect_pc, 32'h0000_0000);
        check("wrap_redirect", {31'd0, redirect}, 32'd1);

        // Sweep every funct3 against comparator combos; the model checks each cycle
        for (int k = 0; k < 32; k++) begin
            logic [4:0] kv;
            kv = 5'(k);
            step();
            if_pc = 32'h1000 + 32'(k % 4) * 4;
            drive_br(kv[2:0], 32'h1000 + 32'(k % 4) * 4, 32'h2000 + 32'(k) * 8,
                     kv[3] ^ kv[0], kv[3], kv[4]);
            ex_valid = (k % 7) != 6;
        end
        step();
        idle_ex();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
